// File: rtl/dense_layer_engine.sv
// dense_layer_engine: fully-connected layer engine. LANES neurons are computed
// in parallel per group, with one input element consumed per cycle, and an
// optional argmax pass runs over the stored activations.

// One MAC lane. The first cycle of a group seeds the accumulator with the bias.
module dense_mac_lane #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      first,
  input  logic signed [WIDTH-1:0]   x,
  input  logic signed [WIDTH-1:0]   w,
  input  logic signed [2*WIDTH-1:0] bias,
  output logic signed [4*WIDTH-1:0] acc
);
  logic signed [2*WIDTH-1:0] prod;
  logic signed [4*WIDTH-1:0] base;

  // Full-precision product; both operands are sign-extended first, so it cannot overflow.
  always_comb begin
    prod = $signed({{WIDTH{x[WIDTH-1]}}, x}) * $signed({{WIDTH{w[WIDTH-1]}}, w});
    base = first ? {{(2*WIDTH){bias[2*WIDTH-1]}}, bias} : acc;
  end

  // Accumulate with two's-complement wrap. There is no saturation.
  always_ff @(posedge clk or negedge reset)
    if (!reset)  acc <= '0;
    else if (en) acc <= base + {{(2*WIDTH){prod[2*WIDTH-1]}}, prod};
endmodule

module dense_layer_engine #(
  parameter  int N_IN      = 196,
  parameter  int N_OUT     = 32,
  parameter  int WIDTH     = 8,
  parameter  int LANES     = 4,
  parameter  int RELU_EN   = 1,
  parameter  int ARGMAX_EN = 0,
  localparam int G         = (N_OUT + LANES - 1) / LANES,
  localparam int AW        = $clog2(G * N_IN),
  localparam int IW        = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int BW        = (G > 1) ? $clog2(G) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         layer_go,
  input  logic [WIDTH*N_IN-1:0]        layer_in,
  output logic [AW-1:0]                weight_addr,
  input  logic [WIDTH*LANES-1:0]       weight_data,
  output logic [BW-1:0]                bias_addr,
  input  logic [2*WIDTH*LANES-1:0]     bias_data,
  output logic [4*WIDTH*N_OUT-1:0]     layer_out,
  output logic [IW-1:0]                max_idx,
  output logic                         busy,
  output logic                         layer_done
);
  localparam int KW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CW = (KW > IW) ? KW : IW;
  localparam int OW = 4 * WIDTH;

  typedef enum logic [2:0] {IDLE, BIAS, MAC, STORE, ARGMAX, DONE} state_t;
  state_t state, state_nx;

  logic [BW-1:0]                    g;
  logic [CW-1:0]                    cnt;   // MAC input index, reused as the argmax scan index
  logic [N_IN-1:0][WIDTH-1:0]       x_q;
  logic [N_OUT-1:0][OW-1:0]         out_q;
  logic [LANES-1:0][OW-1:0]         acc;
  logic [LANES-1:0][WIDTH-1:0]      w_l;
  logic [LANES-1:0][2*WIDTH-1:0]    b_l;
  logic                             last_k, last_g, last_a, mac_en, first_k;
  logic signed [OW-1:0]             cur, best_val, cand_val;
  logic [IW-1:0]                    best_idx, cand_idx;

  assign w_l     = weight_data;
  assign b_l     = bias_data;
  assign last_k  = (cnt == CW'(N_IN - 1));
  assign last_a  = (cnt == CW'(N_OUT - 1));
  assign last_g  = (g == BW'(G - 1));
  assign mac_en  = (state == MAC);
  assign first_k = (cnt == '0);

  // FSM state register.
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nx;

  // Next-state logic. layer_go is only considered in IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (layer_go) state_nx = BIAS;
      BIAS:    state_nx = MAC;
      MAC:     if (last_k) state_nx = STORE;
      STORE:   if (!last_g)            state_nx = BIAS;
               else if (ARGMAX_EN != 0) state_nx = ARGMAX;
               else                    state_nx = DONE;
      ARGMAX:  if (last_a) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Input latch, group counter and the step counter shared by MAC and ARGMAX.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      x_q <= '0;
      g   <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE:   if (layer_go) begin
                  x_q <= layer_in;
                  g   <= '0;
                  cnt <= '0;
                end
        BIAS:   cnt <= '0;
        MAC:    cnt <= cnt + CW'(1);
        STORE:  begin
                  cnt <= '0;
                  if (!last_g) g <= g + BW'(1);
                end
        ARGMAX: cnt <= cnt + CW'(1);
        default: ;
      endcase
    end

  // ROM addressing. A read issued in BIAS or MAC step k returns in the next cycle,
  // so MAC step k consumes the weight for input k.
  always_comb begin
    weight_addr = '0;
    bias_addr   = '0;
    case (state)
      BIAS: begin
        weight_addr = AW'(int'(g) * N_IN);
        bias_addr   = g;
      end
      MAC:  weight_addr = AW'(int'(g) * N_IN + int'(cnt) + 1);
      default: ;
    endcase
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    dense_mac_lane #(.WIDTH(WIDTH)) u_lane (
      .clk  (clk),
      .reset(reset),
      .en   (mac_en),
      .first(first_k),
      .x    (x_q[cnt[KW-1:0]]),
      .w    (w_l[l]),
      .bias (b_l[l]),
      .acc  (acc[l])
    );
  end

  function automatic logic [OW-1:0] act(input logic [OW-1:0] v);
    if (RELU_EN != 0 && v[OW-1]) return '0;
    return v;
  endfunction

  // Store the active group. Lanes past N_OUT have no destination and are dropped.
  always_ff @(posedge clk or negedge reset)
    if (!reset) out_q <= '0;
    else if (state == STORE)
      for (int n = 0; n < N_OUT; n++)
        if (g == BW'(n / LANES)) out_q[n] <= act(acc[n % LANES]);

  // Argmax candidate. The comparison is strict greater-than, so the earliest index wins a tie.
  always_comb begin
    cur      = out_q[cnt[IW-1:0]];
    cand_val = best_val;
    cand_idx = best_idx;
    if (cnt == '0 || cur > best_val) begin
      cand_val = cur;
      cand_idx = cnt[IW-1:0];
    end
  end

  // Argmax scan, one neuron per cycle. max_idx is published only on the final step.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      best_val <= '0;
      best_idx <= '0;
      max_idx  <= '0;
    end else if (state == ARGMAX) begin
      best_val <= cand_val;
      best_idx <= cand_idx;
      if (last_a) max_idx <= cand_idx;
    end

  assign layer_out  = out_q;
  assign busy       = (state != IDLE);
  assign layer_done = (state == DONE);
endmodule

// File: tb/tb_dense_layer_engine.sv
// Bench for dense_layer_engine. Two instances share stimulus:
// dut_a runs ReLU with no argmax, and dut_b runs linear with argmax.
module tb_dense_layer_engine;
  localparam int N_IN = 4, N_OUT = 3, WIDTH = 8, LANES = 2;
  localparam int AW = 3, BW = 1, IW = 2, OW = 4 * WIDTH;

  logic clk = 1'b0, reset = 1'b0, go_a = 1'b0, go_b = 1'b0;
  logic [WIDTH*N_IN-1:0]      layer_in = '0;
  logic [AW-1:0]              wa_a, wa_b;
  logic [BW-1:0]              ba_a, ba_b;
  logic [WIDTH*LANES-1:0]     wd_a = '0, wd_b = '0;
  logic [2*WIDTH*LANES-1:0]   bd_a = '0, bd_b = '0;
  logic [OW*N_OUT-1:0]        out_a, out_b;
  logic [IW-1:0]              idx_a, idx_b;
  logic                       busy_a, busy_b, done_a, done_b;

  int checks = 0, errors = 0;
  int x_v[N_IN];
  int w_v[N_OUT][N_IN];
  int b_v[N_OUT];

  typedef struct packed {
    logic [OW*N_OUT-1:0] out;
    logic [IW-1:0]       idx;
  } exp_t;
  exp_t qa[$], qb[$];

  always #5 clk = ~clk;

  dense_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(WIDTH), .LANES(LANES),
                       .RELU_EN(1), .ARGMAX_EN(0)) dut_a (
    .clk(clk), .reset(reset), .layer_go(go_a), .layer_in(layer_in),
    .weight_addr(wa_a), .weight_data(wd_a), .bias_addr(ba_a), .bias_data(bd_a),
    .layer_out(out_a), .max_idx(idx_a), .busy(busy_a), .layer_done(done_a));

  dense_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(WIDTH), .LANES(LANES),
                       .RELU_EN(0), .ARGMAX_EN(1)) dut_b (
    .clk(clk), .reset(reset), .layer_go(go_b), .layer_in(layer_in),
    .weight_addr(wa_b), .weight_data(wd_b), .bias_addr(ba_b), .bias_data(bd_b),
    .layer_out(out_b), .max_idx(idx_b), .busy(busy_b), .layer_done(done_b));

  // ROM images: weight word (g*N_IN+k) lane l holds the weight for neuron g*LANES+l, input k.
  function automatic logic [WIDTH*LANES-1:0] wrom(input logic [AW-1:0] a);
    logic [WIDTH*LANES-1:0] r;
    int n;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      n = (int'(a) / N_IN) * LANES + l;
      r[l*WIDTH +: WIDTH] = (n < N_OUT) ? WIDTH'(w_v[n][int'(a) % N_IN]) : 8'h5a;
    end
    return r;
  endfunction

  function automatic logic [2*WIDTH*LANES-1:0] brom(input logic [BW-1:0] a);
    logic [2*WIDTH*LANES-1:0] r;
    int n;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      n = int'(a) * LANES + l;
      r[l*2*WIDTH +: 2*WIDTH] = (n < N_OUT) ? (2*WIDTH)'(b_v[n]) : 16'h7fff;
    end
    return r;
  endfunction

  // ROMs with a 1-cycle read latency.
  always @(posedge clk) begin
    wd_a <= wrom(wa_a);
    wd_b <= wrom(wa_b);
    bd_a <= brom(ba_a);
    bd_b <= brom(ba_b);
  end

  // Reference model: wide integer dot product, truncated to the accumulator width.
  function automatic exp_t model(input bit relu);
    exp_t e;
    longint s;
    logic [OW-1:0] v;
    logic signed [OW-1:0] best;
    e = '0;
    for (int n = 0; n < N_OUT; n++) begin
      s = b_v[n];
      for (int k = 0; k < N_IN; k++) s += longint'(x_v[k]) * longint'(w_v[n][k]);
      v = OW'(s);
      if (relu && v[OW-1]) v = '0;
      e.out[n*OW +: OW] = v;
    end
    best = e.out[0 +: OW];
    for (int n = 1; n < N_OUT; n++)
      if ($signed(e.out[n*OW +: OW]) > best) begin
        best  = e.out[n*OW +: OW];
        e.idx = IW'(n);
      end
    return e;
  endfunction

  task automatic load(input int x0, input int x1, input int x2, input int x3,
                      input int w, input int b0, input int b1, input int b2);
    x_v[0] = x0; x_v[1] = x1; x_v[2] = x2; x_v[3] = x3;
    b_v[0] = b0; b_v[1] = b1; b_v[2] = b2;
    for (int n = 0; n < N_OUT; n++)
      for (int k = 0; k < N_IN; k++) w_v[n][k] = w;
    for (int k = 0; k < N_IN; k++) layer_in[k*WIDTH +: WIDTH] = WIDTH'(x_v[k]);
  endtask

  // Runs one layer on both DUTs. It is called right after a negedge and returns on a negedge.
  task automatic run(input string name, input bit hold_go, input bit scramble);
    int lat_a, lat_b, nd_a, nd_b;
    exp_t e;
    logic [WIDTH*N_IN-1:0] saved;
    qa.push_back(model(1'b1));
    qb.push_back(model(1'b0));
    saved = layer_in;
    go_a = 1'b1; go_b = 1'b1;
    @(posedge clk); #1;
    if (!hold_go) begin go_a = 1'b0; go_b = 1'b0; end
    if (scramble) layer_in = $urandom();
    lat_a = -1; lat_b = -1; nd_a = 0; nd_b = 0;
    for (int cnt = 1; cnt <= 40; cnt++) begin
      @(negedge clk);
      if (scramble) layer_in = $urandom();
      if (done_a) begin
        nd_a++; go_a = 1'b0;
        if (lat_a < 0) begin
          lat_a = cnt;
          e = qa.pop_front();
          checks++;
          if (out_a !== e.out) begin
            errors++;
            $display("FAIL %s out_a: got %h, want %h", name, out_a, e.out);
          end
          checks++;
          if (idx_a !== '0) begin
            errors++;
            $display("FAIL %s idx_a: got %0d, want 0", name, idx_a);
          end
        end
      end
      if (done_b) begin
        nd_b++; go_b = 1'b0;
        if (lat_b < 0) begin
          lat_b = cnt;
          e = qb.pop_front();
          checks++;
          if (out_b !== e.out) begin
            errors++;
            $display("FAIL %s out_b: got %h, want %h", name, out_b, e.out);
          end
          checks++;
          if (idx_b !== e.idx) begin
            errors++;
            $display("FAIL %s idx_b: got %0d, want %0d", name, idx_b, e.idx);
          end
        end
      end
    end
    go_a = 1'b0; go_b = 1'b0;
    layer_in = saved;
    checks++;
    if (nd_a !== 1 || lat_a !== 13) begin
      errors++;
      $display("FAIL %s done_a: got %0d pulses at cycle %0d, want 1 at cycle 13", name, nd_a, lat_a);
    end
    checks++;
    if (nd_b !== 1 || lat_b !== 16) begin
      errors++;
      $display("FAIL %s done_b: got %0d pulses at cycle %0d, want 1 at cycle 16", name, nd_b, lat_b);
    end
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_busy: got %b%b, want 00", name, busy_a, busy_b);
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard: %0d/%0d results never produced", name, qa.size(), qb.size());
      qa.delete(); qb.delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({out_a, idx_a, wa_a, ba_a, busy_a, done_a} !== '0) begin
      errors++;
      $display("FAIL %s dut_a: got out=%h idx=%0d wa=%0d ba=%0d busy=%b done=%b, want all 0",
               name, out_a, idx_a, wa_a, ba_a, busy_a, done_a);
    end
    checks++;
    if ({out_b, idx_b, wa_b, ba_b, busy_b, done_b} !== '0) begin
      errors++;
      $display("FAIL %s dut_b: got out=%h idx=%0d wa=%0d ba=%0d busy=%b done=%b, want all 0",
               name, out_b, idx_b, wa_b, ba_b, busy_b, done_b);
    end
  endtask

  task automatic test_reset();
    load(1, 2, 3, 4, 1, 0, -20, 5);
    go_a = 1'b1; go_b = 1'b1;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    check_all_zero("reset_hold");
    go_a = 1'b0; go_b = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    load(1, 2, 3, 4, 1, 0, -20, 5);
    run("basic", 1'b0, 1'b0);
  endtask

  task automatic test_tie();
    load(1, 2, 3, 4, 0, 7, 7, 0);
    run("tie", 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    load(-128, -128, -128, -128, -128, 0, 0, 0);
    run("overflow", 1'b0, 1'b0);
  endtask

  // go is held high for the whole run and layer_in is scrambled after acceptance.
  task automatic test_back_to_back();
    load(1, 2, 3, 4, 1, 0, -20, 5);
    run("back_to_back", 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    int nd;
    load(2, 2, 2, 2, 1, 3, -1, 4);
    go_a = 1'b1; go_b = 1'b1;
    @(posedge clk); #1;
    go_a = 1'b0; go_b = 1'b0;
    for (int cnt = 1; cnt < 9; cnt++) @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid_run");
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_a || done_b) nd++;
    end
    checks++;
    if (nd !== 0) begin
      errors++;
      $display("FAIL reset_mid_run no_done: got %0d pulses, want 0", nd);
    end
    check_all_zero("reset_mid_run_hold");
    reset = 1'b1;
    load(1, 2, 3, 4, 1, 0, -20, 5);
    run("after_reset", 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dense_layer_engine.md
DENSE_LAYER_ENGINE -- requirements
Module: dense_layer_engine

Interface
REQ-001 SHALL have parameter N_IN, default 196: number of layer inputs.
REQ-002 SHALL have parameter N_OUT, default 32: number of neurons.
REQ-003 SHALL have parameter WIDTH, default 8: signed input and weight width.
REQ-004 SHALL have parameter LANES, default 4: parallel MAC lanes, 1 to N_OUT.
REQ-005 SHALL have parameter RELU_EN, default 1: 1 applies ReLU at store, 0 passes the result linear.
REQ-006 SHALL have parameter ARGMAX_EN, default 0: 1 enables the argmax pass.
REQ-007 SHALL have localparams G = ceil(N_OUT/LANES), AW = clog2(G*N_IN) and IW = max(1, clog2(N_OUT)).
REQ-008 SHALL have port clk, input, 1 bit: the single clock; every flop is rising-edge triggered.
REQ-009 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have port layer_go, input, 1 bit: start request.
REQ-011 SHALL have port layer_in, input, WIDTH*N_IN bits: signed inputs; element k is at bits [WIDTH*k +: WIDTH].
REQ-012 SHALL have port weight_addr, output, AW bits: weight ROM address.
REQ-013 SHALL have port weight_data, input, WIDTH*LANES bits: signed weights, one per lane, with 1-cycle read latency.
REQ-014 SHALL have port bias_addr, output, clog2(G) bits (minimum 1 bit): bias ROM address.
REQ-015 SHALL have port bias_data, input, 2*WIDTH*LANES bits: signed biases, with 1-cycle read latency.
REQ-016 SHALL have port layer_out, output, 4*WIDTH*N_OUT bits: signed activations; neuron n is at bits [4*WIDTH*n +: 4*WIDTH].
REQ-017 SHALL have port max_idx, output, IW bits: argmax neuron index.
REQ-018 SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-019 SHALL have port layer_done, output, 1 bit: one-cycle completion pulse.

Function
REQ-020 SHALL use FSM states IDLE, BIAS, MAC, STORE, ARGMAX and DONE.
REQ-021 SHALL, when layer_go=1 in IDLE, latch layer_in into an internal register, clear group counter g, and go to BIAS.
REQ-022 SHALL ignore layer_go in every state other than IDLE; the latched inputs SHALL NOT change mid-run.
REQ-023 BIAS SHALL last 1 cycle and drive bias_addr=g and weight_addr=g*N_IN.
REQ-024 MAC SHALL last N_IN cycles, k = 0..N_IN-1.
REQ-025 In MAC cycle k, each lane l SHALL compute acc_l <= (k==0 ? sext(bias_l) : acc_l) + x[k]*w_l.
REQ-026 In MAC cycle k, weight_addr SHALL be g*N_IN+k+1; in the last MAC cycle the address is don't-care.
REQ-027 Products SHALL be 2*WIDTH signed; accumulators SHALL be 4*WIDTH signed, with two's-complement wrap on overflow and no saturation.
REQ-028 STORE SHALL last 1 cycle and write neuron n = g*LANES+l = act(acc_l) for each lane with n < N_OUT.
REQ-029 STORE SHALL discard lanes with n >= N_OUT; bias_data and weight_data for those lanes are don't-care.
REQ-030 act SHALL be max(0, acc) when RELU_EN=1 and identity when RELU_EN=0.
REQ-031 After STORE, g SHALL increment and go to BIAS; after the last group, go to ARGMAX if ARGMAX_EN=1, else to DONE.
REQ-032 ARGMAX SHALL take N_OUT cycles, scanning neurons 0..N_OUT-1 one per cycle with strict greater-than comparison, so the lowest index wins a tie.
REQ-033 max_idx SHALL update on exit from ARGMAX and otherwise hold.
REQ-034 DONE SHALL assert layer_done for exactly 1 cycle, then return to IDLE.
REQ-035 layer_done SHALL assert exactly G*(N_IN+2) + ARGMAX_EN*N_OUT + 1 cycles after the cycle in which layer_go is sampled.
REQ-036 layer_out SHALL change only in STORE and SHALL hold its value between runs.
REQ-037 layer_done and a new layer_go MAY coincide with no effect on the new run; that layer_go is ignored because the FSM is in DONE.

Reset
REQ-038 While reset=0, FSM SHALL be IDLE, g=0, and all accumulators 0.
REQ-039 While reset=0, layer_out=0, max_idx=0, weight_addr=0, bias_addr=0, busy=0 and layer_done=0.
REQ-040 Reset assertion mid-run SHALL abort the run immediately with no done pulse.
REQ-041 After release from reset, the first layer_go SHALL be accepted on the first rising edge with reset=1.

Verification
Bench configuration: N_IN=4, N_OUT=3, LANES=2, WIDTH=8, ROM model with 1-cycle latency.
REQ-042 Bench SHALL apply x=(1,2,3,4), all weights 1, biases (0,-20,5), RELU_EN=1 -> layer_out=(10,0,15); layer_done at cycle 13 after go.
REQ-043 Bench SHALL repeat REQ-042 with RELU_EN=0 and ARGMAX_EN=1 -> layer_out=(10,-10,15), max_idx=2, layer_done at cycle 16.
REQ-044 Bench SHALL apply a tie case, biases (7,7,0) and weights 0 -> max_idx=0.
REQ-045 Bench SHALL pulse layer_go every cycle during a run -> exactly one layer_done, with results unchanged from a single-go run.
REQ-046 Bench SHALL assert reset=0 during MAC of group 1 -> all outputs 0 within the cycle, no layer_done; a fresh go completes normally.
REQ-047 Bench SHALL apply x = -128 with weights -128 at N_IN=4 -> acc=65536 exact, with no wrap at 4*WIDTH width.
